// File: rtl/platform_manager.sv
// Owns the game's jump platforms: once per VGA frame it checks the doodle for a landing,
// then scrolls and respawns the platforms. It also serves a registered per-pixel platform flag.
module platform_manager #(
    parameter int NUM_PLAT   = 8,
    parameter int PLAT_W     = 64,
    parameter int PLAT_H     = 8,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int MAX_SCROLL = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  scroll_amt,
    input  logic [9:0]  DoodleX,
    input  logic [9:0]  DoodleY,
    input  logic [9:0]  DoodleS,
    input  logic        falling,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        plat_on,
    output logic        land_pulse,
    output logic [9:0]  land_y,
    output logic [15:0] score,
    output logic        busy,
    output logic        frame_overrun
);
    localparam int IDX_W = $clog2(NUM_PLAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);
    localparam logic [10:0] W11     = 11'(PLAT_W);
    localparam logic [10:0] H11     = 11'(PLAT_H);
    localparam logic [10:0] SH11    = 11'(SCREEN_H);
    localparam logic [9:0]  X_SPAN  = 10'(SCREEN_W - PLAT_W);
    localparam logic [9:0]  MAX_SAT = 10'(MAX_SCROLL);

    typedef enum logic [1:0] {IDLE, COLLIDE, SCROLL} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [9:0]         px_q [NUM_PLAT];
    logic [9:0]         px_d [NUM_PLAT];
    logic [9:0]         py_q [NUM_PLAT];
    logic [9:0]         py_d [NUM_PLAT];
    logic [15:0]        lfsr_q, lfsr_d;
    logic               sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic               tick_q, tick_d;
    logic [9:0]         dx_q, dx_d, dy_q, dy_d, ds_q, ds_d, sat_q, sat_d;
    logic               fall_q, fall_d;
    logic               hit_found_q, hit_found_d;
    logic [9:0]         win_y_q, win_y_d;
    logic [9:0]         land_y_q, land_y_d;
    logic [15:0]        score_q, score_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               plat_on_q, plat_on_d;

    logic [10:0] cur_x, cur_y, bottom, ny, ny_wrapped;
    logic        hit_now, wrap;
    logic [9:0]  rnd, new_x, new_y, win_y;
    logic [16:0] score_sum;

    always_comb begin
        sync1_d = frame_clk;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        tick_d  = sync2_q & ~sync3_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Per-platform datapath for whichever platform idx_q currently selects
    always_comb begin
        cur_x      = {1'b0, px_q[idx_q]};
        cur_y      = {1'b0, py_q[idx_q]};
        bottom     = {1'b0, dy_q} + {1'b0, ds_q};
        hit_now    = fall_q && (bottom >= cur_y) && (bottom < cur_y + H11)
                     && ({1'b0, dx_q} + {1'b0, ds_q} > cur_x)
                     && ({1'b0, dx_q} < cur_x + W11 + {1'b0, ds_q});
        ny         = cur_y + {1'b0, sat_q};
        wrap       = ny >= SH11;
        ny_wrapped = ny - SH11;
        new_y      = wrap ? ny_wrapped[9:0] : ny[9:0];
        rnd        = lfsr_q[9:0];
        new_x      = (rnd < X_SPAN) ? rnd : rnd - X_SPAN;
        score_sum  = {1'b0, score_q} + {7'd0, sat_q};
        win_y      = hit_found_q ? win_y_q : cur_y[9:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        ds_d        = ds_q;
        fall_d      = fall_q;
        sat_d       = sat_q;
        hit_found_d = hit_found_q;
        win_y_d     = win_y_q;
        land_y_d    = land_y_q;
        score_d     = score_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q | (tick_q & busy_q);
        px_d        = px_q;
        py_d        = py_q;
        land_pulse  = 1'b0;
        land_y      = land_y_q;
        unique case (state_q)
            IDLE: begin
                if (tick_q) begin
                    dx_d        = DoodleX;
                    dy_d        = DoodleY;
                    ds_d        = DoodleS;
                    fall_d      = falling;
                    sat_d       = (scroll_amt > MAX_SAT) ? MAX_SAT : scroll_amt;
                    hit_found_d = 1'b0;
                    busy_d      = 1'b1;
                    idx_d       = '0;
                    state_d     = COLLIDE;
                end
            end
            COLLIDE: begin
                if (hit_now && !hit_found_q) begin
                    hit_found_d = 1'b1;
                    win_y_d     = cur_y[9:0];
                end
                if (idx_q == LAST_IDX) begin
                    // The strobe is raised on the final compare so it lines up with that cycle
                    if (hit_found_q || hit_now) begin
                        land_pulse = 1'b1;
                        land_y     = win_y;
                        land_y_d   = win_y;
                    end
                    idx_d   = '0;
                    state_d = SCROLL;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            SCROLL: begin
                py_d[idx_q] = new_y;
                if (wrap) px_d[idx_q] = new_x;
                if (idx_q == LAST_IDX) begin
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        plat_on_d = 1'b0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if (({1'b0, DrawX} >= {1'b0, px_q[i]}) && ({1'b0, DrawX} < {1'b0, px_q[i]} + W11)
                && ({1'b0, DrawY} >= {1'b0, py_q[i]}) && ({1'b0, DrawY} < {1'b0, py_q[i]} + H11))
                plat_on_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lfsr_q      <= 16'hACE1;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            tick_q      <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            ds_q        <= '0;
            fall_q      <= 1'b0;
            sat_q       <= '0;
            hit_found_q <= 1'b0;
            win_y_q     <= '0;
            land_y_q    <= '0;
            score_q     <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            plat_on_q   <= 1'b0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                px_q[i] <= 10'(i * 80);
                py_q[i] <= 10'(i * (SCREEN_H / NUM_PLAT));
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            tick_q      <= tick_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            ds_q        <= ds_d;
            fall_q      <= fall_d;
            sat_q       <= sat_d;
            hit_found_q <= hit_found_d;
            win_y_q     <= win_y_d;
            land_y_q    <= land_y_d;
            score_q     <= score_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            plat_on_q   <= plat_on_d;
            px_q        <= px_d;
            py_q        <= py_d;
        end
    end

    assign plat_on       = plat_on_q;
    assign score         = score_q;
    assign busy          = busy_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_platform_manager.sv
// Frame-level bench for platform_manager: a behavioural model of the platform field,
// the landing rule, the saturating score and the LFSR-driven respawn predicts every output.
`timescale 1ns/1ps
module tb_platform_manager;
    localparam int N = 8;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic [9:0]  scroll_amt, DoodleX, DoodleY, DoodleS, DrawX, DrawY;
    logic        falling;
    logic        plat_on, land_pulse, busy, frame_overrun;
    logic [9:0]  land_y;
    logic [15:0] score;

    int vecCount = 0;
    int errCount = 0;
    int clkCount;

    int mx [N];
    int my [N];
    int mScore, mLandY;
    bit mOverrun;
    logic [15:0] lfV;
    int          lfN;

    platform_manager dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .scroll_amt(scroll_amt),
        .DoodleX(DoodleX), .DoodleY(DoodleY), .DoodleS(DoodleS), .falling(falling),
        .DrawX(DrawX), .DrawY(DrawY), .plat_on(plat_on), .land_pulse(land_pulse),
        .land_y(land_y), .score(score), .busy(busy), .frame_overrun(frame_overrun)
    );

    always #5 Clk = ~Clk;

    // Number of clock edges seen since reset was released
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) clkCount <= 0;
        else          clkCount <= clkCount + 1;
    end

    function automatic logic [15:0] lfsrAt(input int n);
        if (n < lfN) begin
            lfN = 0;
            lfV = 16'hACE1;
        end
        while (lfN < n) begin
            lfV = {lfV[14:0], ^(lfV & 16'hB400)};
            lfN++;
        end
        return lfV;
    endfunction

    function automatic bit platHere(input int x, input int y);
        for (int i = 0; i < N; i++)
            if (x >= mx[i] && x < mx[i] + 64 && y >= my[i] && y < my[i] + 8) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mx[i] = i * 80;
            my[i] = i * 60;
        end
        mScore   = 0;
        mLandY   = 0;
        mOverrun = 1'b0;
        lfN      = 0;
        lfV      = 16'hACE1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic probe(input int x, input int y, input string tag);
        @(posedge Clk);
        #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge Clk);
        @(negedge Clk);
        checkOutput(tag, {31'd0, plat_on}, {31'd0, platHere(x, y)});
    endtask

    task automatic probeAll();
        for (int i = 0; i < N; i++) begin
            probe(mx[i], my[i], "plat_on_corner");
            probe(mx[i] + 63, my[i] + 7, "plat_on_far_corner");
            probe(mx[i] + 64, my[i], "plat_on_right_edge");
            probe(mx[i], my[i] + 8, "plat_on_below");
        end
        for (int k = 0; k < 4; k++)
            probe($urandom_range(0, 639), $urandom_range(0, 479), "plat_on_random");
    endtask

    // One frame: raise frame_clk, watch landing/busy timing, then advance the model
    task automatic applyStimulus(input int scroll, input int dx, input int dy, input int ds,
                                 input bit fall, input int gap);
        int r, hitIdx, bottom, sat, ny, pulses, pulseAt, ly, busyFall;
        logic busyAt4;
        logic [15:0] lv;
        int rv;
        @(posedge Clk);
        #1;
        scroll_amt = 10'(scroll);
        DoodleX    = 10'(dx);
        DoodleY    = 10'(dy);
        DoodleS    = 10'(ds);
        falling    = fall;
        frame_clk  = 1'b1;
        r          = clkCount;
        hitIdx     = -1;
        bottom     = dy + ds;
        for (int i = 0; i < N; i++)
            if (hitIdx < 0 && fall && bottom >= my[i] && bottom < my[i] + 8
                && dx + ds > mx[i] && dx < mx[i] + 64 + ds) hitIdx = i;
        pulses = 0; pulseAt = -1; ly = -1; busyFall = -1; busyAt4 = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge Clk);
            #1;
            if (gap > 0 && c == 2)   frame_clk = 1'b0;
            if (gap > 0 && c == gap) frame_clk = 1'b1;
            if (c == 12)             frame_clk = 1'b0;
            @(negedge Clk);
            if (land_pulse === 1'b1) begin
                pulses++;
                if (pulseAt < 0) begin
                    pulseAt = c;
                    ly      = int'(land_y);
                end
            end
            if (c == 4) busyAt4 = busy;
            if (c > 4 && busyFall < 0 && busy === 1'b0) busyFall = c;
        end
        sat = (scroll > 32) ? 32 : scroll;
        if (hitIdx >= 0) mLandY = my[hitIdx];
        for (int i = 0; i < N; i++) begin
            ny = my[i] + sat;
            if (ny >= 480) begin
                my[i] = ny - 480;
                lv    = lfsrAt(r + 12 + i);
                rv    = int'(lv & 16'h03FF);
                mx[i] = (rv < 576) ? rv : rv - 576;
            end else begin
                my[i] = ny;
            end
        end
        mScore = (mScore + sat > 65535) ? 65535 : mScore + sat;
        if (gap > 0) mOverrun = 1'b1;
        checkOutput("land_pulse_count", pulses, (hitIdx >= 0) ? 1 : 0);
        if (hitIdx >= 0) begin
            checkOutput("land_pulse_cycle", pulseAt, 11);
            checkOutput("land_y_at_pulse", ly, mLandY);
        end
        checkOutput("land_y_held", {22'd0, land_y}, mLandY);
        checkOutput("busy_rise", {31'd0, busyAt4}, 1);
        checkOutput("busy_fall_cycle", busyFall, 20);
        checkOutput("score", {16'd0, score}, mScore);
        checkOutput("frame_overrun", {31'd0, frame_overrun}, {31'd0, mOverrun});
    endtask

    task automatic resetMidScroll();
        @(posedge Clk);
        #1;
        scroll_amt = 10'd10;
        DoodleY    = 10'd1000;
        falling    = 1'b0;
        frame_clk  = 1'b1;
        repeat (14) @(posedge Clk);
        #1;
        checkOutput("busy_before_reset", {31'd0, busy}, 1);
        frame_clk = 1'b0;
        Reset_n   = 1'b0;
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_score", {16'd0, score}, 0);
        checkOutput("reset_overrun", {31'd0, frame_overrun}, 0);
        checkOutput("reset_land_y", {22'd0, land_y}, 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        modelReset();
        probeAll();
    endtask

    initial begin
        int k, ds, dy, dx;
        Reset_n = 1'b0; frame_clk = 1'b0; scroll_amt = '0;
        DoodleX = '0; DoodleY = '0; DoodleS = '0; falling = 1'b0;
        DrawX = '0; DrawY = '0;
        modelReset();
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_plat_on", {31'd0, plat_on}, 0);
        checkOutput("reset_land_pulse", {31'd0, land_pulse}, 0);
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_score", {16'd0, score}, 0);
        checkOutput("reset_overrun", {31'd0, frame_overrun}, 0);
        checkOutput("reset_land_y", {22'd0, land_y}, 0);
        Reset_n = 1'b1;

        probe(90, 62, "layout_plat1_inside");
        probe(90, 70, "layout_plat1_below");
        probeAll();

        applyStimulus(0, 100, 52, 8, 1'b1, 0);
        applyStimulus(0, 100, 52, 8, 1'b0, 0);

        repeat (3) applyStimulus(10, $urandom_range(0, 639), 900, 8, 1'b1, 0);
        probe(0, 30, "plat0_after_scroll");
        probeAll();

        applyStimulus(26, $urandom_range(0, 639), 900, 8, 1'b1, 0);
        applyStimulus(10, $urandom_range(0, 639), 900, 8, 1'b1, 0);
        probeAll();

        applyStimulus(500, $urandom_range(0, 639), 900, 8, 1'b1, 0);
        probeAll();

        // Aim the doodle near a random platform so some frames land
        for (int f = 0; f < 8; f++) begin
            k  = $urandom_range(0, N - 1);
            ds = $urandom_range(2, 12);
            dy = my[k] + $urandom_range(0, 9) - ds;
            if (dy < 0) dy = 0;
            dx = mx[k] + $urandom_range(0, 70) - ds;
            if (dx < 0) dx = 0;
            applyStimulus($urandom_range(0, 40), dx, dy, ds, 1'($urandom_range(0, 1)), 0);
        end
        probeAll();

        applyStimulus(7, 300, 1000, 4, 1'b1, 5);
        probeAll();

        resetMidScroll();

        while (mScore < 65535) applyStimulus(600, 300, 1000, 4, 1'b1, 0);
        repeat (2) applyStimulus(600, 300, 1000, 4, 1'b1, 0);
        probeAll();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/platform_manager.md
Name: platform_manager

Overview:
- Owns the set of jump platforms for the game; replaces the constant platform coordinates currently tied off at top level.
- Once per frame (VGA vertical sync edge), checks the doodle against every platform for a landing, then scrolls platforms down by the requested amount.
- Respawns platforms that leave the bottom of the screen at the top, with a pseudo-random X.
- Serves a registered per-pixel "platform here" flag to color_mapper and a landing pulse to jumplogic; accumulates a height score.

Parameters:
NUM_PLAT, 8, number of platforms (power of two, 2..16)
PLAT_W, 64, platform width in pixels
PLAT_H, 8, platform height in pixels
SCREEN_W, 640, visible width
SCREEN_H, 480, visible height
MAX_SCROLL, 32, per-frame scroll saturation limit

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous active-low reset
frame_clk  in  1  VGA_VS, asynchronous to logic; update triggered on its rising edge
scroll_amt  in  10  pixels to move platforms down this frame
DoodleX  in  10  doodle centre X
DoodleY  in  10  doodle centre Y
DoodleS  in  10  doodle half-size
falling  in  1  doodle vertical velocity is downward
DrawX  in  10  current pixel X from vga_controller
DrawY  in  10  current pixel Y from vga_controller
plat_on  out  1  registered: pixel (DrawX, DrawY) lies inside any platform
land_pulse  out  1  one-cycle landing strobe
land_y  out  10  Y (top edge) of the landed platform, held until next landing
score  out  16  accumulated scroll distance, saturating
busy  out  1  frame update in progress
frame_overrun  out  1  sticky: a frame edge arrived while busy

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE; plat_on, land_pulse, busy, frame_overrun = 0; land_y = 0; score = 0.
  - LFSR = 16'hACE1.
  - Platform i: X = i*80, Y = i*(SCREEN_H/NUM_PLAT); i.e. Y = 0, 60, ..., 420 at defaults.
  - Reset mid-update aborts the update; all platform registers return to these values.
- frame_clk passes a two-flop synchronizer, then a rising-edge detect, giving a one-cycle frame_tick.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every Clk. Never reaches zero.
- FSM: IDLE -> COLLIDE -> SCROLL -> IDLE. Index counter idx runs 0..NUM_PLAT-1 in each phase, one platform per cycle.
- IDLE:
  - On frame_tick: latch DoodleX/Y/S, falling, and sat = min(scroll_amt, MAX_SCROLL).
  - Set busy=1, idx=0, go to COLLIDE.
- COLLIDE (NUM_PLAT cycles), per platform i, computed at 11-bit width (no underflow):
  - bottom = DoodleY + DoodleS.
  - hit_i = falling && bottom >= Y_i && bottom < Y_i + PLAT_H && DoodleX + DoodleS > X_i && DoodleX < X_i + PLAT_W + DoodleS.
  - The lowest-index hit wins. On the last COLLIDE cycle: if any hit, land_pulse=1 for exactly one cycle and land_y = winning Y_i.
- SCROLL (NUM_PLAT cycles), per platform, 11-bit arithmetic:
  - ny = Y_i + sat.
  - If ny >= SCREEN_H: Y_i = ny - SCREEN_H (spacing preserved); X_i = r if r < SCREEN_W-PLAT_W, else r-(SCREEN_W-PLAT_W), where r = LFSR[9:0].
  - Otherwise Y_i = ny.
  - The final SCROLL cycle also does score = min(score + sat, 16'hFFFF). Then busy=0, go to IDLE.
- Latency:
  - frame_tick is asserted 3 Clk cycles after the frame_clk rise.
  - land_pulse occurs NUM_PLAT cycles after frame_tick.
  - busy deasserts 2*NUM_PLAT+1 cycles after frame_tick.
- frame_tick while busy: the update is dropped and frame_overrun is set (sticky until reset). The in-progress update is unaffected.
- sat = 0: no movement and no respawn, but the collision phase still runs.
- plat_on:
  - Combinational OR over all platforms of (X_i <= DrawX < X_i+PLAT_W && Y_i <= DrawY < Y_i+PLAT_H), registered once: 1 Clk latency.
  - During SCROLL it may show a mix of old and new positions. This is acceptable, since updates occur in vertical blank.

Test Plan:
- Reset layout: release Reset_n, then DrawX=90, DrawY=62 -> plat_on=1 one cycle later (platform 1: X=80, Y=60). DrawX=90, DrawY=70 -> plat_on=0.
- Landing: DoodleX=100, DoodleY=52, DoodleS=8, falling=1, one frame_clk rise -> land_pulse high exactly one cycle, 11 cycles after the rise (3 + NUM_PLAT), land_y=60. Same stimulus with falling=0 -> no pulse.
- Scroll + score: scroll_amt=10 for 3 frames -> platform 0 at Y=30, score=30.
- Saturation: scroll_amt=500 -> platforms move 32, score increases by 32. Preload score near FFFF via repeated frames -> score sticks at 16'hFFFF.
- Respawn: scroll until platform 7 reaches Y=476, then apply scroll_amt=10 -> its Y=6 and X < 576.
- Overrun/reset: second frame_clk rise 5 cycles after the first -> frame_overrun=1, single update applied. Pulse Reset_n low mid-SCROLL -> all Y return to i*60, busy=0.
